// File: rtl/sonic_tx_arbiter.sv
// sonic_tx_arbiter: round-robin owner selection for the shared PCIe TX port; grant one cycle after request, two dead cycles between owners.
// Optional ownership watchdog enabled by defining SONIC_TX_ARB_WATCHDOG_EN.
module sonic_tx_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_BUSY_CYCLES = 4096,
  localparam int IW             = $clog2(NUM_REQ)
) (
  input  logic               clk_in,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req_ready,
  input  logic [NUM_REQ-1:0] req_busy,
  output logic [NUM_REQ-1:0] tx_sel,
  output logic [NUM_REQ-1:0] tx_ready_others,
  output logic               grant_valid,
  output logic [IW-1:0]      grant_idx,
  output logic               proto_err,
  output logic               wd_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_RELEASE} state_t;

  state_t             r_state;
  logic [IW-1:0]      r_grant_idx;
  logic [IW-1:0]      r_last_grant;
  logic [NUM_REQ-1:0] r_tx_sel;
  logic               r_grant_valid;
  logic               r_proto_err;
  logic [IW-1:0]      w_pick;
  logic [IW-1:0]      w_cand;
  logic               w_any;
  logic               w_wd_hit;
  logic [NUM_REQ-1:0] w_owner_oh;
  logic [NUM_REQ-1:0] w_pick_oh;

  assign w_owner_oh      = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_idx;
  assign w_pick_oh       = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
  assign tx_sel          = r_tx_sel;
  assign grant_valid     = r_grant_valid;
  assign grant_idx       = r_grant_idx;
  assign proto_err       = r_proto_err;
  assign tx_ready_others = r_grant_valid ? ~w_owner_oh : '0;

  // Scan downward so the last hit is the nearest candidate after last_grant.
  always_comb begin
    w_pick = r_last_grant;
    w_any  = 1'b0;
    w_cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = IW'((int'(r_last_grant) + k) % NUM_REQ);
      if (req_ready[w_cand]) begin
        w_pick = w_cand;
        w_any  = 1'b1;
      end
    end
  end

`ifdef SONIC_TX_ARB_WATCHDOG_EN
  logic [15:0] r_wd_cnt;

  assign w_wd_hit = r_grant_valid && (r_wd_cnt == 16'(MAX_BUSY_CYCLES - 1));

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_IDLE && w_any) begin
      r_wd_cnt <= '0;
    end else if (r_grant_valid) begin
      r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end
`else
  assign w_wd_hit = 1'b0;
`endif

  assign wd_timeout = w_wd_hit;

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_grant_idx   <= '0;
      r_last_grant  <= IW'(NUM_REQ - 1);
      r_tx_sel      <= '0;
      r_grant_valid <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      if (r_state == S_IDLE ? (|req_busy) : (|(req_busy & ~w_owner_oh))) begin
        r_proto_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state       <= S_GRANT;
            r_grant_idx   <= w_pick;
            r_last_grant  <= w_pick;
            r_tx_sel      <= w_pick_oh;
            r_grant_valid <= 1'b1;
          end
        end
        S_GRANT: begin
          if (w_wd_hit || (!req_busy[r_grant_idx] && !req_ready[r_grant_idx])) begin
            r_state       <= S_RELEASE;
            r_tx_sel      <= '0;
            r_grant_valid <= 1'b0;
          end else if (req_busy[r_grant_idx]) begin
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_wd_hit || !req_busy[r_grant_idx]) begin
            r_state       <= S_RELEASE;
            r_tx_sel      <= '0;
            r_grant_valid <= 1'b0;
          end
        end
        S_RELEASE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

endmodule
